// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: SOF, CMD, DATH, DATL, SUM -> register strobes.
// Discards bad, errored or stalled frames and counts them.
module uart_cmd_parser #(
  parameter logic [7:0]  P_SOF = 8'hAA,
  parameter logic [15:0] P_TMO = 16'd50000
) (
  input  logic        FPGA_CLK,
  input  logic        FPGA_RST_N,
  input  logic        IRX_DVLD,
  input  logic        IRX_ERR,
  input  logic [7:0]  IRX_DT,
  output logic        OWR_EN,
  output logic        ORD_EN,
  output logic [6:0]  OADDR,
  output logic [15:0] OWDATA,
  output logic        OBUSY,
  output logic        OFRM_ERR,
  output logic [7:0]  OERR_CNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATH,
    ST_DATL,
    ST_SUM
  } state_t;

  logic [1:0]  rst_sync_q;
  logic        rst_n;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  dath_q, dath_d;
  logic [7:0]  datl_q, datl_d;
  logic [15:0] tmo_q, tmo_d;

  logic        wr_q, rd_q, ferr_q;
  logic [6:0]  addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  errcnt_q;

  logic        good;
  logic        bad;
  logic        tmo_hit;
  logic        accept;
  logic        discard;
  logic [7:0]  sum;

  // Reset asserts immediately, releases two clock edges later.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  assign good = IRX_DVLD & ~IRX_ERR;
  assign bad  = IRX_DVLD &  IRX_ERR;
  assign sum  = cmd_q ^ dath_q ^ datl_q;

  // A byte in the same cycle beats the timeout.
  assign tmo_hit = (state_q != ST_IDLE) & ~IRX_DVLD &
                   (tmo_q == P_TMO - 16'd2);

  // Next-state, byte capture and accept/discard decisions.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dath_d  = dath_q;
    datl_d  = datl_q;
    accept  = 1'b0;
    discard = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (good && IRX_DT == P_SOF) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (good) begin
          cmd_d   = IRX_DT;
          state_d = ST_DATH;
        end
      end
      ST_DATH: begin
        if (good) begin
          dath_d  = IRX_DT;
          state_d = ST_DATL;
        end
      end
      ST_DATL: begin
        if (good) begin
          datl_d  = IRX_DT;
          state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        if (good) begin
          accept  = (IRX_DT == sum);
          discard = (IRX_DT != sum);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && (bad || tmo_hit)) begin
      discard = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // Inter-byte timer restarts on every byte and idles at zero.
  always_comb begin
    if (state_q == ST_IDLE || IRX_DVLD) tmo_d = 16'd0;
    else                                tmo_d = tmo_q + 16'd1;
  end

  // FSM, captured bytes and timer.
  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'd0;
      dath_q  <= 8'd0;
      datl_q  <= 8'd0;
      tmo_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dath_q  <= dath_d;
      datl_q  <= datl_d;
      tmo_q   <= tmo_d;
    end
  end

  // Registered strobes, held address/data and saturating error count.
  always_ff @(posedge FPGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ferr_q   <= 1'b0;
      addr_q   <= 7'd0;
      wdata_q  <= 16'd0;
      errcnt_q <= 8'd0;
    end else begin
      wr_q   <= accept &  cmd_q[7];
      rd_q   <= accept & ~cmd_q[7];
      ferr_q <= discard;
      if (accept) begin
        addr_q  <= cmd_q[6:0];
        wdata_q <= {dath_q, datl_q};
      end
      if (discard && errcnt_q != 8'hFF) errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign OWR_EN   = wr_q;
  assign ORD_EN   = rd_q;
  assign OFRM_ERR = ferr_q;
  assign OADDR    = addr_q;
  assign OWDATA   = wdata_q;
  assign OERR_CNT = errcnt_q;
  assign OBUSY    = (state_q != ST_IDLE);

endmodule
